// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: double-buffered frame input, blank gap between digits,
// and 16-level PWM brightness. Frames are swapped only at the end of a complete scan.
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 2500,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic [7*NUM_DIGITS-1:0] frame_data,
   input  logic                    frame_valid,
   output logic                    frame_ready,
   input  logic [3:0]              brightness,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_done
);

   localparam int SLOT_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
   localparam int FRAME_W = 7 * NUM_DIGITS;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   generate
      if (SCAN_DIV <= BLANK_CYCLES + 1) begin : g_bad_scan_div
         $error("seg7_scan_driver: SCAN_DIV must exceed BLANK_CYCLES+1");
      end
      if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
         $error("seg7_scan_driver: NUM_DIGITS must be in 2..8");
      end
   endgenerate

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

   scan_state_t        state;
   logic [SLOT_W-1:0]  slot_cnt;
   logic [SLOT_W-1:0]  slot_nxt;
   logic [IDX_W-1:0]   digit_idx;
   logic [3:0]         pwm_cnt;
   logic               slot_wrap;
   logic               frame_end;

   logic [FRAME_W-1:0] disp_buf;
   logic [FRAME_W-1:0] pend_buf;
   logic               pend_full;

   logic               lit_p0;
   logic [6:0]         pat_p0;

   // Physical level for the segment lines; a dark digit always shows the off pattern.
   function automatic logic [6:0] seg_level(input logic [6:0] pat, input logic on);
      logic [6:0] lvl;
      lvl = on ? pat : 7'h00;
      return (SEG_ACTIVE_LOW != 0) ? ~lvl : lvl;
   endfunction

   function automatic logic [NUM_DIGITS-1:0] dig_level(input logic [IDX_W-1:0] idx,
                                                       input logic on);
      logic [NUM_DIGITS-1:0] sel;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         sel[i] = on && (idx == IDX_W'(i));
      end
      return (DIG_ACTIVE_LOW != 0) ? ~sel : sel;
   endfunction

   assign slot_wrap   = (slot_cnt == SLOT_LAST);
   assign frame_end   = slot_wrap && (digit_idx == IDX_LAST);
   assign slot_nxt    = slot_wrap ? '0 : slot_cnt + 1'b1;
   assign frame_ready = !pend_full;

   // Stage p0: decide lighting and fetch the current digit's pattern.
   assign lit_p0 = (state == ST_DRIVE) && ena && (pwm_cnt <= brightness);

   always_comb begin
      pat_p0 = 7'h00;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            pat_p0 = disp_buf[7*i +: 7];
         end
      end
   end

   // Stage p1: scan counters, blank/drive FSM and registered pin drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_BLANK;
         slot_cnt   <= '0;
         digit_idx  <= '0;
         pwm_cnt    <= 4'd0;
         seg_out    <= SEG_OFF;
         dig_en     <= DIG_OFF;
         frame_done <= 1'b0;
      end else begin
         slot_cnt   <= slot_nxt;
         frame_done <= frame_end;
         seg_out    <= seg_level(pat_p0, lit_p0);
         dig_en     <= dig_level(digit_idx, lit_p0);

         if (slot_wrap) begin
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
         end

         case (state)
            ST_BLANK: begin
               if (slot_nxt >= BLANK_END) begin
                  state   <= ST_DRIVE;
                  pwm_cnt <= 4'd0;
               end
            end
            ST_DRIVE: begin
               pwm_cnt <= pwm_cnt + 4'd1;
               if (slot_nxt < BLANK_END) begin
                  state <= ST_BLANK;
               end
            end
            default: state <= ST_BLANK;
         endcase
      end
   end

   // Pending/display double buffer; ready is low while pending is full, so swap and accept never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_buf  <= '0;
         pend_buf  <= '0;
         pend_full <= 1'b0;
      end else if (frame_end && pend_full) begin
         disp_buf  <= pend_buf;
         pend_full <= 1'b0;
      end else if (frame_valid && !pend_full) begin
         pend_buf  <= frame_data;
         pend_full <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-level reference model predicts every
// post-edge output, and a separate monitor pops and compares one expectation per clock.
module tb_seg7_scan_driver;

   localparam int N   = 4;
   localparam int SD  = 8;
   localparam int BLK = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b0;
   logic [27:0]   frame_data = '0;
   logic          frame_valid = 1'b0;
   logic          frame_ready;
   logic [3:0]    brightness = 4'd0;
   logic [6:0]    seg_out;
   logic [3:0]    dig_en;
   logic          frame_done;

   seg7_scan_driver #(
      .NUM_DIGITS    (N),
      .SCAN_DIV      (SD),
      .BLANK_CYCLES  (BLK),
      .SEG_ACTIVE_LOW(0),
      .DIG_ACTIVE_LOW(1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .frame_data (frame_data),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .brightness (brightness),
      .seg_out    (seg_out),
      .dig_en     (dig_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] dig;
      logic       ready;
      logic       done;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   // Reference state: position within a full scan, shown frame and queued frame.
   int          t_pos;
   logic [27:0] m_disp;
   logic [27:0] m_pend;
   bit          m_full;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
      end
   endtask

   always @(posedge clk) begin : model
      exp_t e;
      int   slot;
      int   dig;
      int   k;
      bit   lit;
      bit   boundary;
      if (!rst_n) begin
         t_pos  = 0;
         m_disp = '0;
         m_pend = '0;
         m_full = 1'b0;
         e      = '{7'h00, 4'hF, 1'b1, 1'b0};
      end else begin
         slot     = t_pos % SD;
         dig      = (t_pos / SD) % N;
         k        = slot - BLK;
         lit      = (slot >= BLK) && (ena == 1'b1) && ((k % 16) <= int'(brightness));
         e.seg    = lit ? m_disp[dig*7 +: 7] : 7'h00;
         e.dig    = lit ? ~(4'b0001 << dig) : 4'hF;
         boundary = (t_pos == N*SD - 1);
         e.done   = boundary;
         if (boundary && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
         end else if (frame_valid && !m_full) begin
            m_pend = frame_data;
            m_full = 1'b1;
         end
         e.ready = !m_full;
         t_pos   = (t_pos + 1) % (N*SD);
      end
      exp_q.push_back(e);
   end

   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty at %0t: got no expectation, expected one", $time);
      end else begin
         e = exp_q.pop_front();
         check("seg_out",     32'(seg_out),     32'(e.seg));
         check("dig_en",      32'(dig_en),      32'(e.dig));
         check("frame_ready", 32'(frame_ready), 32'(e.ready));
         check("frame_done",  32'(frame_done),  32'(e.done));
      end
   end

   // Asynchronous reset must clear the pins without waiting for a clock edge.
   always @(negedge rst_n) begin : async_rst_monitor
      #1;
      check("async_rst_seg",   32'(seg_out),     32'h00);
      check("async_rst_dig",   32'(dig_en),      32'hF);
      check("async_rst_ready", 32'(frame_ready), 32'h1);
      check("async_rst_done",  32'(frame_done),  32'h0);
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [27:0] d);
      int n;
      n           = 0;
      frame_valid = 1'b1;
      frame_data  = d;
      while (!frame_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got ready=%0b, expected 1 within 200 cycles", frame_ready);
      end
      @(negedge clk);
      frame_valid = 1'b0;
      frame_data  = 28'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!frame_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_done_timeout: got 0, expected a pulse within 100 cycles");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n      = 1'b1;
      ena        = 1'b1;
      brightness = 4'd15;
      run(40);

      send(28'h0FE6DBF);
      run(80);

      brightness = 4'd0;
      run(40);
      brightness = 4'd3;
      run(40);
      brightness = 4'd15;

      send(28'($urandom));
      send(28'($urandom));
      run(80);

      run(3);
      ena = 1'b0;
      run(13);
      ena = 1'b1;
      run(40);

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) brightness = 4'($urandom);
         if ($urandom_range(0, 15) == 0) ena = ~ena;
         frame_valid = ($urandom_range(0, 3) == 0);
         frame_data  = 28'($urandom);
      end
      frame_valid = 1'b0;
      ena         = 1'b1;
      brightness  = 4'd15;

      wait_done();
      send(28'($urandom));
      run(12);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(40);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
